// File: rtl/hsm_axil_pkg.sv
// hsm_axil_pkg: response codes, FSM states and HSM register map for the AXI4-Lite initiator
package hsm_axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h4;
  localparam logic [3:0] REG_DATA_IN  = 4'h8;
  localparam logic [3:0] REG_DATA_OUT = 4'hC;
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
endpackage

// File: rtl/hsm_axil_master.sv
// hsm_axil_master: single-outstanding AXI4-Lite initiator driven by a valid/ready command port
module hsm_axil_master
  import hsm_axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  state_t state, state_n;
  logic acc, aw_hs, w_hs, wait_st, aw_done, w_done, write_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0] resp_q;
  logic [CW-1:0] cnt;
  assign cmd_ready     = state == IDLE && !M_AXI_ARESET;
  assign acc           = cmd_valid && cmd_ready;
  assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;
  assign wait_st       = state inside {WR, WR_RESP, RD_ADDR, RD_DATA};
  assign busy          = state != IDLE;
  assign rsp_valid     = state == RSP;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = state == WR && !aw_done;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = state == WR && !w_done;
  assign M_AXI_BREADY  = state == WR_RESP;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = state == RD_ADDR;
  assign M_AXI_RREADY  = state == RD_DATA;
  always_ff @(posedge M_AXI_ACLK) begin
    state <= M_AXI_ARESET ? IDLE : state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? (cmd_write ? WR : RD_ADDR) : IDLE;
      WR:      state_n = (aw_done || aw_hs) && (w_done || w_hs) ? WR_RESP : WR;
      WR_RESP: state_n = M_AXI_BVALID ? RSP : WR_RESP;
      RD_ADDR: state_n = M_AXI_ARREADY ? RD_DATA : RD_ADDR;
      RD_DATA: state_n = M_AXI_RVALID ? RSP : RD_DATA;
      RSP:     state_n = rsp_ready ? IDLE : RSP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (acc) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        cnt     <= '0;
      end
      if (state == WR) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done || w_hs;
      end
      if (state == WR_RESP && M_AXI_BVALID) begin
        resp_q  <= M_AXI_BRESP;
        rdata_q <= '0;
      end
      if (state == RD_DATA && M_AXI_RVALID) begin
        resp_q  <= M_AXI_RRESP;
        rdata_q <= M_AXI_RDATA;
      end
      if (wait_st && cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
      if (wait_st && TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hsm_axil_master.sv
// tb_hsm_axil_master: table-driven and directed checks of the AXI4-Lite initiator against a small slave model
module tb_hsm_axil_master;
  import hsm_axil_pkg::*;
  localparam int TO = 16;
  typedef struct {
    logic        write;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, rsp_valid, rsp_ready = 1'b0, rsp_write, busy, timeout_err;
  logic [3:0] cmd_addr = '0, cmd_wstrb = '0;
  logic [31:0] cmd_wdata = '0, rsp_rdata;
  logic [1:0] rsp_resp;
  logic [3:0] awaddr, araddr, wstrb;
  logic [2:0] awprot, arprot;
  logic [31:0] wdata, rdata;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic b_hang = 1'b0, r_hang = 1'b0;
  logic [1:0] b_resp = 2'b00, r_resp = 2'b00;
  int aw_cnt, w_cnt, ar_cnt;
  logic got_aw, got_w, bv_q, rv_q, r_pend;
  logic [3:0] sa, ra, ss;
  logic [31:0] sd, rd;
  logic [31:0] mem [4];
  logic [3:0] ea, es, era;
  logic [31:0] ed;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, viol = 0;
  logic ar_hold = 1'b0, aw_hold = 1'b0;
  logic [3:0] ar_prev = '0, aw_prev = '0;
  int nvec = 0, nerr = 0;
  vec_t vt [10];
  always #5 clk = ~clk;
  hsm_axil_master #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy), .timeout_err(timeout_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );
  assign awready = awvalid && (aw_cnt + 1 >= aw_dly);
  assign wready  = wvalid && (w_cnt + 1 >= w_dly);
  assign arready = arvalid && (ar_cnt + 1 >= ar_dly);
  assign bvalid  = bv_q && !b_hang;
  assign bresp   = b_resp;
  assign rvalid  = rv_q;
  assign rresp   = r_resp;
  assign rdata   = rd;
  assign ea      = (awvalid && awready) ? awaddr : sa;
  assign ed      = (wvalid && wready) ? wdata : sd;
  assign es      = (wvalid && wready) ? wstrb : ss;
  assign era     = (arvalid && arready) ? araddr : ra;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; bv_q <= 1'b0; rv_q <= 1'b0; r_pend <= 1'b0;
      sa <= '0; sd <= '0; ss <= '0; ra <= '0; rd <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin got_aw <= 1'b1; sa <= awaddr; end
      if (wvalid && wready) begin got_w <= 1'b1; sd <= wdata; ss <= wstrb; end
      if (bvalid && bready) bv_q <= 1'b0;
      if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
        mem[ea[3:2]] <= merge(mem[ea[3:2]], ed, es);
        bv_q <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (rvalid && rready) rv_q <= 1'b0;
      if (arvalid && arready) begin r_pend <= 1'b1; ra <= araddr; end
      if (((arvalid && arready) || r_pend) && !r_hang) begin
        rv_q <= 1'b1; r_pend <= 1'b0; rd <= mem[era[3:2]];
      end
    end
  end
  always @(negedge clk) begin
    if (awvalid) aw_hi++;
    if (wvalid) w_hi++;
    if (arvalid) ar_hi++;
    if (bready && (awvalid || wvalid)) viol++;
    if ((bready || rready) && (awvalid || wvalid || arvalid)) viol++;
    if (ar_hold && (!arvalid || araddr != ar_prev)) viol++;
    if (aw_hold && (!awvalid || awaddr != aw_prev)) viol++;
    if (awprot != 3'b000 || arprot != 3'b000) viol++;
    ar_hold = arvalid && !arready && !rst;
    aw_hold = awvalid && !awready && !rst;
    ar_prev = araddr;
    aw_prev = awaddr;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin cyc(); lat++; end
  endtask
  task automatic run(input vec_t v, input int idx);
    int aw0, w0, ar0, lat, k;
    aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly; b_resp = v.resp; r_resp = v.resp;
    k = 0;
    while (!cmd_ready && k < 50) begin cyc(); k++; end
    chk($sformatf("v%0d cmd_ready", idx), cmd_ready, 1);
    aw0 = aw_hi; w0 = w_hi; ar0 = ar_hi;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    cyc();
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d rsp_write", idx), rsp_write, v.write);
    chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_resp", idx), rsp_resp, v.resp);
    chk($sformatf("v%0d busy", idx), busy, 1);
    chk($sformatf("v%0d aw_cycles", idx), aw_hi - aw0, v.write ? (v.aw_dly > 1 ? v.aw_dly : 1) : 0);
    chk($sformatf("v%0d w_cycles", idx), w_hi - w0, v.write ? (v.w_dly > 1 ? v.w_dly : 1) : 0);
    chk($sformatf("v%0d ar_cycles", idx), ar_hi - ar0, v.write ? 0 : (v.ar_dly > 1 ? v.ar_dly : 1));
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_done", idx), {rsp_valid, busy, cmd_ready}, 3'b001);
  endtask
  initial begin
    int lat, k;
    logic stable;
    vec_t v;
    vt[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, RESP_OKAY,   32'h0,        3};
    vt[1] = '{1'b0, 4'h4, 32'h0,        4'h0, 0, 0, 3, RESP_OKAY,   32'hDEADBEEF, 5};
    vt[2] = '{1'b1, 4'h8, 32'h12345678, 4'h3, 0, 0, 0, RESP_OKAY,   32'h0,        3};
    vt[3] = '{1'b0, 4'h8, 32'h0,        4'h0, 0, 0, 0, RESP_OKAY,   32'h00005678, 3};
    vt[4] = '{1'b1, 4'hC, 32'hA5A5A5A5, 4'hF, 5, 0, 0, RESP_OKAY,   32'h0,        7};
    vt[5] = '{1'b1, 4'h0, 32'hCAFEF00D, 4'h1, 0, 5, 0, RESP_OKAY,   32'h0,        7};
    vt[6] = '{1'b0, 4'hC, 32'h0,        4'h0, 0, 0, 0, RESP_OKAY,   32'hA5A5A5A5, 3};
    vt[7] = '{1'b1, 4'h4, 32'h11111111, 4'hF, 3, 3, 0, RESP_SLVERR, 32'h0,        5};
    vt[8] = '{1'b0, 4'h0, 32'h0,        4'h0, 0, 0, 0, RESP_DECERR, 32'h0000000D, 3};
    vt[9] = '{1'b0, 4'h4, 32'h0,        4'h0, 0, 0, 0, RESP_EXOKAY, 32'h11111111, 3};
    repeat (3) cyc();
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset outputs", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy, timeout_err}, 8'h00);
    chk("reset regs", {awaddr, wdata, rsp_rdata, rsp_resp, rsp_write}, '0);
    rst = 1'b0;
    cyc();
    chk("idle cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 10; i++) run(vt[i], i);
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_resp = RESP_OKAY; r_resp = RESP_OKAY;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hC;
    cyc();
    cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h600DCAFE; cmd_wstrb = 4'hF;
    wait_rsp(lat);
    chk("bp latency", lat, 3);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_rdata !== 32'hA5A5A5A5 || rsp_resp !== RESP_OKAY || rsp_write !== 1'b0 || cmd_ready !== 1'b0) stable = 1'b0;
      cyc();
    end
    chk("bp stable", stable, 1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("bp after rsp", {rsp_valid, cmd_ready}, 2'b01);
    cyc();
    cmd_valid = 1'b0;
    chk("bp next accepted", {busy, cmd_ready}, 2'b10);
    wait_rsp(lat);
    chk("bp second write", {rsp_valid, rsp_write, rsp_resp}, 4'b1100);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    r_hang = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
    cyc();
    cmd_valid = 1'b0;
    repeat (15) cyc();
    chk("timeout before", timeout_err, 0);
    cyc();
    chk("timeout at 16", timeout_err, 1);
    repeat (20) cyc();
    chk("timeout waiting", {busy, rready, rsp_valid, arvalid}, 4'b1100);
    r_hang = 1'b0;
    wait_rsp(lat);
    chk("timeout late rsp", {rsp_valid, rsp_resp}, 3'b100);
    chk("timeout late data", rsp_rdata, 32'h600DCAFE);
    chk("timeout sticky", timeout_err, 1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    b_hang = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
    cyc();
    cmd_valid = 1'b0;
    k = 0;
    while (!bready && k < 50) begin cyc(); k++; end
    chk("mid reset in WR_RESP", bready, 1);
    rst = 1'b1;
    cyc();
    chk("mid reset valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b00000);
    chk("mid reset status", {busy, rsp_valid, timeout_err, cmd_ready}, 4'b0000);
    rst = 1'b0; b_hang = 1'b0;
    cyc();
    chk("post reset cmd_ready", cmd_ready, 1);
    v = '{1'b1, 4'h8, 32'h0BADF00D, 4'hF, 0, 0, 0, RESP_OKAY, 32'h0, 3};
    run(v, 10);
    v = '{1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 0, RESP_OKAY, 32'h0BADF00D, 3};
    run(v, 11);
    chk("post reset no timeout", timeout_err, 0);
    chk("protocol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
